uart_rx_controller: RTL
=======================

# uart_rx_controller

Sequences the UART receive path around the oversampling bit detector: generates the 16x oversample enable from a programmable divisor, assembles detected bits LSB-first into a data word, validates the frame on the stop-bit strobe, and buffers completed words in a small FIFO. The host drains the FIFO over a valid/ready handshake. Sticky framing and overrun status bits are cleared by software. Sits between the synchronized RX bit detector and the host bus interface.

## Interface
- DATA_BITS, 8: data bits per frame, LSB first.
- FIFO_DEPTH, 4: receive FIFO entries, power of two, at least 2.
- DIV_WIDTH, 16: width of the baud divisor.

Reset is rst_n, synchronous, active-low. Clock is clk.
- clk  in  1  peripheral clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  receiver enable
- baud_div  in  DIV_WIDTH  oversample period minus 1, in clk cycles
- sample_tick  out  1  one-cycle oversample enable to the detector
- det_active  in  1  detector is inside data or stop bits
- det_bit_ready  in  1  one-cycle strobe: det_rx_bit is a new data bit
- det_rx_bit  in  1  sampled bit value
- det_done  in  1  one-cycle strobe: end of stop bit
- det_framing_err  in  1  qualifies det_done: stop bit sampled low
- rx_data  out  DATA_BITS  FIFO head word
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  host accepts head word
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- framing_err  out  1  sticky error flag
- overrun_err  out  1  sticky error flag
- err_clear  in  1  clears both sticky flags
- busy  out  1  FSM not in IDLE

## Operation
- Divider:
  - div_cnt counts 0..baud_div.
  - sample_tick=1 in the cycle where div_cnt==baud_div, and div_cnt wraps to 0 in the same cycle.
  - baud_div=0 gives a tick every cycle.
  - A baud_div change takes effect at the next wrap. If div_cnt already exceeds the new value, it wraps on the next cycle.
- FSM states:
  - IDLE: clear shift register and bit_cnt. Go to RECV on det_active=1.
  - RECV: on det_bit_ready, shift det_rx_bit into the MSB and shift right, so the first bit lands in bit 0 after DATA_BITS shifts. bit_cnt increments, saturating at DATA_BITS. Strobes beyond DATA_BITS are ignored. On det_done, go to IDLE and commit.
  - Commit on det_done:
    - The frame is good if det_framing_err=0 and bit_cnt==DATA_BITS. A good frame is pushed to the FIFO.
    - Otherwise the word is discarded and framing_err is set.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - Pop when rx_valid and rx_ready are both high.
  - Push when full: the word is dropped and overrun_err is set. Existing contents are unchanged.
  - Pop and push in the same cycle while full: both succeed and count is unchanged. overrun_err is not set.
- Sticky flags: err_clear and a new error in the same cycle leave the flag set.
- enable=0:
  - sample_tick is forced to 0 and div_cnt to 0.
  - The FSM is forced to IDLE and any in-flight word is discarded with no error.
  - FIFO contents and flags are retained, and host pops still work.
- Reset values:
  - div_cnt=0, FSM=IDLE, FIFO empty.
  - sample_tick=0, rx_valid=0, fifo_count=0, rx_data=0, framing_err=0, overrun_err=0, busy=0.

## Timing
- det_done at cycle N: FIFO write at edge N, so rx_valid=1 and rx_data are valid in cycle N+1.
- rx_valid and rx_data are combinational from the FIFO head. A pop at cycle N presents the next entry in N+1.
- A sticky flag rises in the cycle after the triggering det_done. err_clear takes effect at the next edge.
- busy is registered and rises in the cycle after det_active is first seen.
- First tick after enable rises: baud_div+1 cycles later.

## Structure
- Package uart_pkg holds:
  - rx_state_t enum (IDLE, RECV).
  - Defaults for DATA_BITS, FIFO_DEPTH and OVERSAMPLE=16.
- Sub-module rx_fifo: synchronous FIFO with push, pop, full, empty and count.
- Divider and FSM are inline.

## Test plan
- Reset with baud_div=3 and enable=1: sample_tick pulses every 4 cycles, and all outputs are 0 during reset.
- Good frame 8'hA5 (bits 1,0,1,0,0,1,0,1 in order) then det_done with det_framing_err=0: rx_data=8'hA5 and rx_valid=1 one cycle after det_done. A pop returns rx_valid=0.
- det_done with det_framing_err=1 after 8 bits, then a second case with det_done after only 5 bits: nothing is pushed, and framing_err=1 in each case until err_clear.
- Push 5 frames (8'h01..8'h05) with rx_ready=0: fifo_count=4, overrun_err=1, and pops return 01,02,03,04.
- FIFO full, with det_done and a pop in the same cycle: count stays 4, overrun_err=0, and the new word appears last.
- enable dropped mid-frame after 3 bits: busy=0 next cycle, no push, no error, FIFO contents intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART receive controller.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    localparam int DATA_BITS_DEF  = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int DIV_WIDTH_DEF  = 16;
    localparam int OVERSAMPLE     = 16;

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous receive FIFO: circular buffer with wrapping pointers.
// Pointers carry one extra bit so full and empty are distinguishable.
module rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO still lands when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since reads are masked when empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: oversample divider, bit assembly FSM, frame commit
// into the receive FIFO, and sticky framing/overrun status.
//
// state | meaning
// IDLE  | waiting for the detector to start a frame; assembly cleared
// RECV  | collecting data bits; det_done commits or rejects the frame
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    output logic                          sample_tick,
    input  logic                          det_active,
    input  logic                          det_bit_ready,
    input  logic                          det_rx_bit,
    input  logic                          det_done,
    input  logic                          det_framing_err,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          overrun_err,
    input  logic                          err_clear,
    output logic                          busy
);

    localparam int                 CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]   BITS_FULL = CNT_W'(DATA_BITS);

    logic [DIV_WIDTH-1:0] div_cnt;
    rx_state_t            state, state_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
    logic                 frame_push;
    logic                 frame_bad;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 overrun_set;

    // Oversample divider; >= makes a shrunk baud_div wrap on the next cycle
    always_ff @(posedge clk) begin
        if (!rst_n || !enable)
            div_cnt <= '0;
        else if (div_cnt >= baud_div)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_WIDTH'(1);
    end

    assign sample_tick = rst_n && enable && (div_cnt == baud_div);

    // FSM and assembly registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
        end
    end

    assign busy = (state != IDLE);

    // Next-state, bit assembly and frame commit decision
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        frame_push  = 1'b0;
        frame_bad   = 1'b0;
        case (state)
            IDLE: begin
                shreg_nxt   = '0;
                bit_cnt_nxt = '0;
                if (det_active) state_nxt = RECV;
            end
            RECV: begin
                if (det_bit_ready && (bit_cnt != BITS_FULL)) begin
                    shreg_nxt   = {det_rx_bit, shreg[DATA_BITS-1:1]};
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                end
                if (det_done) begin
                    state_nxt = IDLE;
                    if (!det_framing_err && (bit_cnt == BITS_FULL))
                        frame_push = 1'b1;
                    else
                        frame_bad = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Disabling abandons the frame silently
        if (!enable) begin
            state_nxt  = IDLE;
            frame_push = 1'b0;
            frame_bad  = 1'b0;
        end
    end

    assign fifo_pop    = rx_valid && rx_ready;
    assign overrun_set = frame_push && fifo_full && !fifo_pop;
    assign rx_valid    = !fifo_empty;

    rx_fifo #(
        .DATA_W (DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (frame_push),
        .push_data (shreg),
        .pop       (fifo_pop),
        .rd_data   (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sticky status; a new error wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (frame_bad)      framing_err <= 1'b1;
            else if (err_clear) framing_err <= 1'b0;
            if (overrun_set)    overrun_err <= 1'b1;
            else if (err_clear) overrun_err <= 1'b0;
        end
    end

endmodule
